// File: rtl/prio_enc_seg.sv
// prio_enc_seg: debounced priority encoder driving two seven-segment digits.
//
// The request vector is sampled every cycle and, once it has been steady long
// enough, committed. The index of the highest set bit of the committed vector
// is shown on pos and decoded onto HEX0 (low nibble) and HEX1 (high nibble).
//
// Ports:
//   clk    - single clock, rising edge
//   rst_n  - asynchronous active-low reset
//   in     - WIDTH-bit request vector
//   en     - encode enable; pos reads 0 while low
//   pos    - registered highest-set-bit index of the committed vector
//   run    - registered, committed vector is non-zero
//   upd    - registered one-cycle pulse after a commit that changed the vector
//   busy   - combinational, sampled input differs from committed vector
//   HEX0   - combinational seven-segment {g..a}, active-low, low nibble of pos
//   HEX1   - combinational seven-segment, high nibble of pos (blank if POS_W <= 4)
//
// Build option: define PRIO_ENC_SEG_DEBOUNCE_EN to enable the stability
// filter. Without it, a sampled value is committed one edge after sampling.
module prio_enc_seg #(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           in,
  input  logic                       en,
  output logic [$clog2(WIDTH)-1:0]   pos,
  output logic                       run,
  output logic                       upd,
  output logic                       busy,
  output logic [6:0]                 HEX0,
  output logic [6:0]                 HEX1
);

  localparam int unsigned POS_W = $clog2(WIDTH);

  // Elaboration-time parameter legality checks.
  if (WIDTH < 4 || WIDTH > 256 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("prio_enc_seg: WIDTH must be a power of two in 4..256");
  end
  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 255) begin : g_bad_stable
    $error("prio_enc_seg: STABLE_CYCLES must be in 1..255");
  end

  logic [WIDTH-1:0] samp;
  logic [WIDTH-1:0] cmt;
  logic [WIDTH-1:0] cmt_nxt;
  logic             commit;
  logic [POS_W-1:0] pos_nxt;
  logic [7:0]       pos8;

  // Index of the highest set bit; 0 for an all-zero vector.
  function automatic logic [POS_W-1:0] msb_idx(input logic [WIDTH-1:0] v);
    msb_idx = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (v[i]) msb_idx = POS_W'(i);
    end
  endfunction

  // Active-low {g,f,e,d,c,b,a} hex digit decode.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0:    seg7 = 7'b1000000;
      4'h1:    seg7 = 7'b1111001;
      4'h2:    seg7 = 7'b0100100;
      4'h3:    seg7 = 7'b0110000;
      4'h4:    seg7 = 7'b0011001;
      4'h5:    seg7 = 7'b0010010;
      4'h6:    seg7 = 7'b0000010;
      4'h7:    seg7 = 7'b1111000;
      4'h8:    seg7 = 7'b0000000;
      4'h9:    seg7 = 7'b0010000;
      4'hA:    seg7 = 7'b0001000;
      4'hB:    seg7 = 7'b0000011;
      4'hC:    seg7 = 7'b1000110;
      4'hD:    seg7 = 7'b0100001;
      4'hE:    seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

`ifdef PRIO_ENC_SEG_DEBOUNCE_EN
  localparam int unsigned    CNT_W   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Stability counter: restarts on any change, saturates at CNT_MAX.
  always_comb begin
    cnt_nxt = '0;
    commit  = 1'b0;
    if (in == samp) begin
      cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
      commit  = (cnt == CNT_MAX) && (samp != cmt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt_nxt;
  end
`else
  // No filter: any sampled difference is committed on the next edge.
  assign commit = (samp != cmt);
`endif

  // Next committed vector and the encoder output it implies.
  always_comb begin
    cmt_nxt = cmt;
    if (commit) cmt_nxt = samp;
    pos_nxt = en ? msb_idx(cmt_nxt) : '0;
  end

  // Sample, commit and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp <= '0;
      cmt  <= '0;
      pos  <= '0;
      run  <= 1'b0;
      upd  <= 1'b0;
    end else begin
      samp <= in;
      cmt  <= cmt_nxt;
      pos  <= pos_nxt;
      run  <= (cmt_nxt != '0);
      upd  <= commit;
    end
  end

  assign busy = (samp != cmt);

  // Display decode; upper digit is blanked when pos fits in one nibble.
  assign pos8 = 8'(pos);
  assign HEX0 = seg7(pos8[3:0]);
  assign HEX1 = (POS_W <= 4) ? 7'b1111111 : seg7(pos8[7:4]);

endmodule

// File: doc/prio_enc_seg.md
PRIO_ENC_SEG -- requirements
Module: prio_enc_seg

Interface
REQ-001 SHALL have parameter WIDTH, default 16, number of request inputs; legal values are powers of two from 4 to 256.
REQ-002 SHALL have parameter STABLE_CYCLES, default 4, debounce depth; legal values are 1 to 255.
REQ-003 SHALL derive POS_W = clog2(WIDTH) internally; POS_W is not overridable.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit, reset; asynchronous and active-low.
REQ-006 SHALL have port in, input, WIDTH bits, request vector from switches or an upstream block.
REQ-007 SHALL have port en, input, 1 bit, encode enable.
REQ-008 SHALL have port pos, output, POS_W bits, registered index of the highest set bit of the committed vector.
REQ-009 SHALL have port run, output, 1 bit, registered; high when the committed vector is non-zero.
REQ-010 SHALL have port upd, output, 1 bit, one-cycle pulse marking a commit that changed the committed vector.
REQ-011 SHALL have port busy, output, 1 bit, high while the sampled input differs from the committed vector.
REQ-012 SHALL have port HEX0, output, 7 bits, low nibble of pos on a seven-segment display.
REQ-013 SHALL have port HEX1, output, 7 bits, high nibble of pos on a seven-segment display.

Function
REQ-014 SHALL register in into samp at every edge, and SHALL keep a stability counter cnt: cleared when in != samp, otherwise saturating increment to STABLE_CYCLES-1.
REQ-015 SHALL commit samp into cmt at an edge where in == samp, cnt == STABLE_CYCLES-1 and samp != cmt; a value held steadily is therefore committed at the (STABLE_CYCLES+1)th rising edge at which it is present.
REQ-016 SHALL reset cnt to 0 on any input change before commit, so glitches shorter than STABLE_CYCLES+1 edges never commit.
REQ-017 SHALL update pos and run at every edge from the next-state cmt and en: pos = en ? index of highest set bit : 0; run = (cmt != 0), independent of en.
REQ-018 SHALL produce pos = 0 for both cmt = 0 and cmt = 1; run distinguishes the two cases.
REQ-019 SHALL assert upd for exactly the one cycle after a commit edge, independent of en; back-to-back commits yield separate pulses.
REQ-020 SHALL make an en change visible on pos after one edge, and SHALL NOT generate upd for an en change.
REQ-021 SHALL drive busy combinationally as (samp != cmt).
REQ-022 SHALL decode HEX0 and HEX1 combinationally from pos, zero-extended to 8 bits; encoding is {g,f,e,d,c,b,a}, active-low, hex digits 0-F ('0'=1000000, '1'=1111001, '7'=1111000, 'F'=0001110).
REQ-023 SHALL blank HEX1 (1111111) when POS_W <= 4.

Reset
REQ-024 SHALL, while rst_n is low, asynchronously force samp=0, cnt=0, cmt=0, pos=0, run=0, upd=0; busy then reads 0, HEX0 shows '0', and HEX1 shows '0' or blank.
REQ-025 SHALL, after reset is released, treat any pending filter progress as discarded; an input present across reset release commits STABLE_CYCLES+1 edges after release.

Configuration
REQ-026 SHALL support macro PRIO_ENC_SEG_DEBOUNCE_EN; when it is defined, behaviour is as per REQ-014..REQ-016.
REQ-027 SHALL, when PRIO_ENC_SEG_DEBOUNCE_EN is undefined, remove cnt and STABLE_CYCLES from the logic, and commit samp into cmt at every edge where samp != cmt (in-to-pos latency 2 edges); all other requirements are unchanged.

Verification (WIDTH=16, STABLE_CYCLES=4, macro defined unless noted)
REQ-028 SHALL cover: reset, then in=16'h0000, en=1 for 10 cycles -> pos=0, run=0, upd never high, HEX0=1000000, HEX1=1111111.
REQ-029 SHALL cover: in=16'h0081 held -> busy high for 4 cycles, then pos=7, run=1, HEX0=1111000, and upd high exactly 1 cycle.
REQ-030 SHALL cover: in=16'h8000 pulsed for 3 edges, then returned to 16'h0000 -> no commit, upd never high, pos stays 0.
REQ-031 SHALL cover: cmt=16'h8000 with en toggled 1->0->1 -> pos goes 15->0->15 one edge after each toggle, run stays 1, no upd, HEX0 goes 0001110->1000000->0001110.
REQ-032 SHALL cover: rst_n asserted mid-filter with in=16'h0004 at cnt=2, released 1 cycle later -> all outputs 0 immediately, pos=2 at the 5th edge after release.
REQ-033 SHALL cover, with the macro undefined: in changes 0001->0002->0001 on consecutive edges -> pos follows 0,1,0 with 2-edge latency, and upd pulses on each change.
